// File: rtl/ram_arbiter2_if.sv
// ============================================================================
// Module   : ram_arbiter2_if
// Function : Requester-side command/response bundle for ram_arbiter2.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ram_arbiter2_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int ADDRESS_WIDTH = $clog2(DEPTH);

  logic                     req;
  logic                     wr_en;
  logic [ADDRESS_WIDTH-1:0] data_address;
  logic [WIDTH-1:0]         data_in;
  logic                     gnt;
  logic                     rvalid;
  logic [WIDTH-1:0]         data_out;

  // Requester side issues commands and consumes grant/read return.
  modport master (
    output req, wr_en, data_address, data_in,
    input  gnt, rvalid, data_out
  );

  modport slave (
    input  req, wr_en, data_address, data_in,
    output gnt, rvalid, data_out
  );
endinterface

`default_nettype wire

// File: rtl/ram_arbiter2.sv
// ============================================================================
// Module   : ram_arbiter2
// Function : Round-robin arbiter sharing one single-port sync RAM between two
//            requesters, steering each one-cycle-latency read to its owner.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ram_arbiter2 #(
  parameter int  WIDTH         = 8,
  parameter int  DEPTH         = 8,
  localparam int ADDRESS_WIDTH = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ram_arbiter2_if.slave            a,
  ram_arbiter2_if.slave            b,
  output logic                     ram_wr_en,
  output logic [ADDRESS_WIDTH-1:0] ram_data_address,
  output logic [WIDTH-1:0]         ram_data_in,
  input  logic [WIDTH-1:0]         ram_data_out
);

  typedef enum logic [0:0] {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_e;

  sel_e r_prio;
  sel_e r_rd_owner;
  logic r_rd_pend;

  logic w_req_a;
  logic w_req_b;
  logic w_gnt_a;
  logic w_gnt_b;
  logic w_rd_gnt;

  // Requests are masked while reset is held so no RAM write can slip out.
  assign w_req_a = a.req & rst_n;
  assign w_req_b = b.req & rst_n;

  assign w_gnt_a  = w_req_a & (~w_req_b | (r_prio == SEL_A));
  assign w_gnt_b  = w_req_b & (~w_req_a | (r_prio == SEL_B));
  assign w_rd_gnt = (w_gnt_a & ~a.wr_en) | (w_gnt_b & ~b.wr_en);

  always_comb begin
    ram_wr_en        = 1'b0;
    ram_data_address = '0;
    ram_data_in      = '0;
    if (w_gnt_a) begin
      ram_wr_en        = a.wr_en;
      ram_data_address = a.data_address;
      ram_data_in      = a.data_in;
    end else if (w_gnt_b) begin
      ram_wr_en        = b.wr_en;
      ram_data_address = b.data_address;
      ram_data_in      = b.data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio     <= SEL_A;
      r_rd_pend  <= 1'b0;
      r_rd_owner <= SEL_A;
    end else begin
      // Last winner drops to lowest priority; idle cycles keep the order.
      if (w_gnt_a) begin
        r_prio <= SEL_B;
      end else if (w_gnt_b) begin
        r_prio <= SEL_A;
      end
      r_rd_pend <= w_rd_gnt;
      if (w_rd_gnt) begin
        r_rd_owner <= w_gnt_b ? SEL_B : SEL_A;
      end
    end
  end

  assign a.gnt      = w_gnt_a;
  assign b.gnt      = w_gnt_b;
  assign a.rvalid   = r_rd_pend & (r_rd_owner == SEL_A);
  assign b.rvalid   = r_rd_pend & (r_rd_owner == SEL_B);
  // Both consumers see the RAM output; each qualifies it with its own rvalid.
  assign a.data_out = ram_data_out;
  assign b.data_out = ram_data_out;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter2.sv
// ============================================================================
// Module   : tb_ram_arbiter2
// Function : Directed + random bench for ram_arbiter2 with a behavioural RAM
//            and a transaction-level reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ram_arbiter2;
  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AW = $clog2(D);

  logic          clk;
  logic          rst_n;
  logic          ram_wr_en;
  logic [AW-1:0] ram_data_address;
  logic [W-1:0]  ram_data_in;
  logic [W-1:0]  ram_data_out;

  ram_arbiter2_if #(.WIDTH(W), .DEPTH(D)) ia ();
  ram_arbiter2_if #(.WIDTH(W), .DEPTH(D)) ib ();

  ram_arbiter2 #(.WIDTH(W), .DEPTH(D)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .a                (ia),
    .b                (ib),
    .ram_wr_en        (ram_wr_en),
    .ram_data_address (ram_data_address),
    .ram_data_in      (ram_data_in),
    .ram_data_out     (ram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM: registered read, read-old-data on write.
  logic [W-1:0] ram_mem [D];
  always @(posedge clk) begin
    if (ram_wr_en) ram_mem[ram_data_address] <= ram_data_in;
    ram_data_out <= ram_mem[ram_data_address];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: memory contents, who won last, and the expected return.
  logic [W-1:0] shadow    [D];
  bit           shadow_ok [D];
  bit           m_last_a   = 1'b0;
  bit           m_ret_v    = 1'b0;
  bit           m_ret_b    = 1'b0;
  bit           m_ret_known = 1'b0;
  logic [W-1:0] m_ret_d    = '0;

  initial for (int i = 0; i < D; i++) shadow_ok[i] = 1'b0;

  always @(negedge clk) begin
    bit            win_a, win_b, win, wr;
    logic [AW-1:0] ad;
    logic [W-1:0]  dn;
    if (!rst_n) begin
      chk("rst_gnt",    {ia.gnt, ib.gnt}, 0);
      chk("rst_wr",     ram_wr_en, 0);
      chk("rst_addr",   ram_data_address, 0);
      chk("rst_din",    ram_data_in, 0);
      chk("rst_rvalid", {ia.rvalid, ib.rvalid}, 0);
      m_last_a = 1'b0;
      m_ret_v  = 1'b0;
    end else begin
      chk("a_rvalid", ia.rvalid, m_ret_v && !m_ret_b);
      chk("b_rvalid", ib.rvalid, m_ret_v && m_ret_b);
      if (m_ret_v && m_ret_known)
        chk(m_ret_b ? "b_data" : "a_data", m_ret_b ? ib.data_out : ia.data_out, m_ret_d);
      // The requester that did not win most recently is preferred.
      win_a = ia.req && (!ib.req || !m_last_a);
      win_b = ib.req && !win_a;
      win   = win_a || win_b;
      chk("a_gnt", ia.gnt, win_a);
      chk("b_gnt", ib.gnt, win_b);
      wr = 1'b0; ad = '0; dn = '0;
      if (win_a) begin wr = ia.wr_en; ad = ia.data_address; dn = ia.data_in; end
      if (win_b) begin wr = ib.wr_en; ad = ib.data_address; dn = ib.data_in; end
      chk("ram_wr",   ram_wr_en, wr);
      chk("ram_addr", ram_data_address, ad);
      chk("ram_din",  ram_data_in, dn);
      m_ret_v     = win && !wr;
      m_ret_b     = win_b;
      m_ret_d     = shadow[ad];
      m_ret_known = shadow_ok[ad];
      if (win && wr) begin
        shadow[ad]    = dn;
        shadow_ok[ad] = 1'b1;
      end
      if (win) m_last_a = win_a;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input bit rq, input bit we, input int ad, input int dn);
    ia.req = rq; ia.wr_en = we; ia.data_address = AW'(ad); ia.data_in = W'(dn);
  endtask

  task automatic set_b(input bit rq, input bit we, input int ad, input int dn);
    ib.req = rq; ib.wr_en = we; ib.data_address = AW'(ad); ib.data_in = W'(dn);
  endtask

  bit a_got, b_got;

  initial begin
    rst_n = 1'b0;
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Fill memory so every read has a known expected value.
    for (int i = 0; i < D; i++) begin
      set_a(1, 1, i, i * 'h11);
      tick();
    end
    set_a(0, 0, 0, 0);
    tick();

    // A writes 0x5A to 3, then reads it back.
    set_a(1, 1, 3, 'h5A);
    tick();
    set_a(1, 0, 3, 0);
    tick();
    set_a(0, 0, 0, 0);
    @(negedge clk);
    chk("wr_rd_valid", ia.rvalid, 1);
    chk("wr_rd_data",  ia.data_out, 'h5A);
    chk("wr_rd_bvld",  ib.rvalid, 0);
    tick();
    @(negedge clk);
    chk("wr_rd_once", ia.rvalid, 0);
    tick();

    // Contention straight after reset: A, B, A, B, ...
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_a(1, 0, 1, 0);
    set_b(1, 0, 2, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("cont_order", ia.gnt, (k % 2) == 0);
      tick();
    end
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    repeat (2) tick();

    // Collision, A preferred: B reads the newly written value.
    set_a(1, 1, 5, 'h77);
    set_b(1, 0, 5, 0);
    tick();
    set_a(0, 0, 0, 0);
    tick();
    set_b(0, 0, 0, 0);
    @(negedge clk);
    chk("coll_new", ib.data_out, 'h77);
    tick();

    // Collision, B preferred: B reads the old value before A's write.
    set_a(1, 0, 0, 0);
    tick();
    set_a(0, 0, 0, 0);
    tick();
    set_a(1, 1, 6, 'hAB);
    set_b(1, 0, 6, 0);
    tick();
    set_b(0, 0, 0, 0);
    @(negedge clk);
    chk("coll_old_gnt", ia.gnt, 1);
    chk("coll_old",     ib.data_out, 'h66);
    tick();
    set_a(0, 0, 0, 0);
    tick();

    // Reset lands while B's read is returning.
    set_b(1, 0, 2, 0);
    tick();
    set_b(0, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_rd", ib.rvalid, 0);
    tick();
    rst_n = 1'b1;
    set_a(1, 0, 1, 0);
    set_b(1, 0, 2, 0);
    @(negedge clk);
    chk("rst_prio_a", ia.gnt, 1);
    tick();
    set_a(0, 0, 0, 0);
    tick();
    set_b(0, 0, 0, 0);
    tick();

    // Priority holds across idle cycles.
    set_a(1, 0, 0, 0);
    tick();
    set_a(0, 0, 0, 0);
    repeat (3) tick();
    set_a(1, 0, 4, 0);
    set_b(1, 0, 7, 0);
    @(negedge clk);
    chk("prio_hold", ib.gnt, 1);
    tick();
    set_b(0, 0, 0, 0);
    tick();
    set_a(0, 0, 0, 0);
    tick();

    // Random traffic obeying the hold-until-granted protocol.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      a_got = ia.gnt;
      b_got = ib.gnt;
      tick();
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
      if (!ia.req || a_got)
        set_a($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, D - 1)), int'($urandom_range(0, 255)));
      if (!ib.req || b_got)
        set_b($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, D - 1)), int'($urandom_range(0, 255)));
    end
    rst_n = 1'b1;
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_arbiter2.md
# ram_arbiter2

Two-port round-robin arbiter that shares one single-port synchronous RAM (registered read, one-cycle read latency, read-old-data on write) between two requesters, A and B. It grants at most one access per cycle. It steers each read result back to the requester that issued it, and alternates priority when both requesters contend. It sits between two client blocks and the RAM instance, driving the RAM's wr_en, data_in and data_address and consuming its data_out.

## Interface
- WIDTH, 8, data width; must match the RAM.
- DEPTH, 8, RAM word count; ADDRESS_WIDTH = $clog2(DEPTH) (localparam).
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a_req, b_req  input  1  access request; held with command stable until granted.
- a_wr_en, b_wr_en  input  1  1 = write, 0 = read.
- a_data_address, b_data_address  input  ADDRESS_WIDTH  word address.
- a_data_in, b_data_in  input  WIDTH  write data.
- a_gnt, b_gnt  output  1  combinational; high in the cycle the request is accepted.
- a_rvalid, b_rvalid  output  1  registered; read data valid, one cycle after a read grant.
- a_data_out, b_data_out  output  WIDTH  read data, valid while the matching rvalid is high.
- ram_wr_en  output  1  to RAM wr_en.
- ram_data_address  output  ADDRESS_WIDTH  to RAM data_address.
- ram_data_in  output  WIDTH  to RAM data_in.
- ram_data_out  input  WIDTH  from RAM data_out.

## Operation
- State:
  - prio (1 bit; 0 = A preferred, 1 = B preferred).
  - rd_pend (1 bit; a read is returning this cycle).
  - rd_owner (1 bit; 0 = A, 1 = B).
- Grant, combinational:
  - Only a_req: grant A.
  - Only b_req: grant B.
  - Both: grant the requester selected by prio.
  - Neither: no grant.
  - At most one gnt is high per cycle.
- RAM drive, combinational:
  - Granted requester's wr_en, address and data_in go to the ram_* ports.
  - No grant: ram_wr_en = 0, ram_data_address = 0, ram_data_in = 0.
- prio update at the clock edge:
  - After a grant, prio points to the other requester, so the last winner becomes lowest priority.
  - No grant: prio holds.
- Read return:
  - On a granted read, rd_pend <= 1 and rd_owner <= the granted requester; otherwise rd_pend <= 0.
  - a_rvalid = rd_pend & ~rd_owner; b_rvalid = rd_pend & rd_owner. Both are registered state decodes.
  - a_data_out and b_data_out both pass ram_data_out through. The consumer qualifies with its own rvalid.
- Writes produce no rvalid. The gnt cycle is the write acknowledge.
- Back-to-back grants are allowed every cycle, and reads may stream, because returning data never collides.

## Timing
- Reset (rst_n low, asynchronous):
  - prio = 0, rd_pend = 0, rd_owner = 0, so a_rvalid = b_rvalid = 0.
  - With req inputs low: a_gnt = b_gnt = 0, ram_wr_en = 0, ram_data_address = 0, ram_data_in = 0.
  - Grant logic is gated while rst_n is low, so no gnt is issued and ram_wr_en = 0.
- Read latency:
  - Grant in cycle N; the RAM samples at the end of N.
  - rvalid and data are valid for exactly one cycle, N+1. There is no backpressure; the requester must accept the data.
- Write: grant in cycle N; memory updated at the end of N. A read granted in N+1 to the same address returns the new value in N+2.
- Contention: with both requesting continuously, grants alternate A, B, A, B… starting from A after reset.
- Requester protocol: command inputs are stable while req is high and gnt is low. A requester may deassert req in the cycle after gnt, or keep it high to issue its next command.
- Reset mid-operation: a read granted in the cycle before reset asserts is dropped (rvalid forced 0). prio returns to A.
- Address range: addresses ≥ DEPTH (non-power-of-2 DEPTH) are passed through unchanged. The result is undefined, and the requester is responsible for staying in range.

## Test plan
- Reset then idle: rst_n low 3 cycles, no req -> all outputs 0. After release, still all 0 and no ram_wr_en pulse.
- Single-requester write then read: A writes 0x5A to address 3 (a_gnt in cycle N), then reads address 3 (gnt in N+1) -> a_rvalid high in N+2 only, a_data_out = 0x5A, b_rvalid stays 0.
- Contention: both requesters hold reads for 6 cycles (A to address 1 = 0x11, B to address 2 = 0x22) -> grant order A,B,A,B,A,B. rvalid alternates one cycle later with data 0x11/0x22 to the correct owner.
- Write/read collision: A writes 0x77 to address 5 while B reads address 5; A wins by prio -> B is granted the next cycle and B's read returns 0x77. With prio = B instead, B reads the old value, then A's write lands.
- Reset mid-read: B granted a read in cycle N; rst_n pulsed low during N+1 before the edge -> b_rvalid = 0. After release, simultaneous requests grant A first.
- Priority hold: A granted, then 3 idle cycles, then both request -> B granted first.
